axis_uncompress_range_multi: RTL and testbench

- Expands compressed run descriptors {start, length-1} into an AXI-stream of addresses start, start±STEP, start±2·STEP, …
- Generalised successor of the single-lane range expander. Adds configurable stride, increment/decrement mode, multi-lane output beats with tkeep, and tlast framing per run or per input packet.
- Sits between descriptor producers (e.g. compressed address tables) and address-consuming engines.

---
 rtl/axis_uncompress_range_multi.sv | 134 +++++++++++++
 tb/tb_axis_uncompress_range_multi.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uncompress_range_multi.sv
// Run-descriptor expander: turns {start, length-1} descriptors into an
// AXI-stream of strided addresses, LANES addresses per beat, with tkeep
// marking the valid lanes of the last beat and tlast per run or per packet.
module axis_uncompress_range_multi #(
  parameter int ASIZE     = 8,
  parameter int LSIZE     = 8,
  parameter int STEP      = 1,
  parameter int LANES     = 1,
  parameter     DIR       = "INC",
  parameter     LAST_MODE = "RUN"
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [ASIZE+LSIZE-1:0]   zip_tdata,
  input  logic                     zip_tvalid,
  input  logic                     zip_tlast,
  output logic                     zip_tready,
  output logic [LANES*ASIZE-1:0]   unzip_tdata,
  output logic [LANES-1:0]         unzip_tkeep,
  output logic                     unzip_tvalid,
  output logic                     unzip_tlast,
  input  logic                     unzip_tready,
  output logic                     busy
);

  localparam int RW = LSIZE + 1;
  localparam bit IS_DEC   = (DIR == "DEC");
  localparam bit LAST_RUN = (LAST_MODE == "RUN");
  // Address advance per accepted beat, already reduced modulo 2^ASIZE.
  localparam logic [ASIZE-1:0] ADV = ASIZE'(LANES * STEP);

  if (STEP < 1 || LANES < 1 || LANES > 8 ||
      !(DIR == "INC" || DIR == "DEC") ||
      !(LAST_MODE == "RUN" || LAST_MODE == "PKT")) begin : g_bad_params
    $error("axis_uncompress_range_multi: illegal STEP/LANES/DIR/LAST_MODE");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [ASIZE-1:0]  cur;
  logic [RW-1:0]     remain;
  logic              pkt_flag;

  logic              final_beat;
  logic              accept;
  logic              handshake;
  logic              load;
  logic [ASIZE-1:0]  nxt_cur;
  logic [RW-1:0]     nxt_rem;
  logic              nxt_pkt;
  logic [LANES*ASIZE-1:0] beat_data;
  logic [LANES-1:0]  beat_keep;
  logic              beat_last;

  function automatic logic [ASIZE-1:0] lane_off(input int unsigned k);
    return ASIZE'(k * STEP);
  endfunction

  // Handshake decode and combinational descriptor-ready (zero-bubble chaining)
  always_comb begin
    final_beat = (state == RUN) && (32'(remain) <= 32'(LANES));
    zip_tready = !rst && ((state == IDLE) || (final_beat && unzip_tready));
    accept     = zip_tvalid && zip_tready;
    handshake  = unzip_tvalid && unzip_tready;
  end

  // Next run position and the beat it produces; outputs are registered from
  // the next position so the beat is valid the cycle after accept/advance.
  always_comb begin
    load    = 1'b0;
    nxt_cur = cur;
    nxt_rem = remain;
    nxt_pkt = pkt_flag;
    if (accept) begin
      load    = 1'b1;
      nxt_cur = zip_tdata[ASIZE+LSIZE-1:LSIZE];
      nxt_rem = RW'(zip_tdata[LSIZE-1:0]) + RW'(1);
      nxt_pkt = zip_tlast;
    end else if (handshake && !final_beat) begin
      load    = 1'b1;
      nxt_cur = IS_DEC ? cur - ADV : cur + ADV;
      nxt_rem = remain - RW'(LANES);
    end
    beat_data = '0;
    beat_keep = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (k < 32'(nxt_rem)) begin
        beat_keep[k] = 1'b1;
        beat_data[k*ASIZE +: ASIZE] = IS_DEC ? nxt_cur - lane_off(k)
                                             : nxt_cur + lane_off(k);
      end
    end
    beat_last = (32'(nxt_rem) <= 32'(LANES)) && (LAST_RUN || nxt_pkt);
  end

  // FSM with run counters and registered stream outputs
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cur          <= '0;
      remain       <= '0;
      pkt_flag     <= 1'b0;
      unzip_tvalid <= 1'b0;
      unzip_tdata  <= '0;
      unzip_tkeep  <= '0;
      unzip_tlast  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      cur      <= nxt_cur;
      remain   <= nxt_rem;
      pkt_flag <= nxt_pkt;
      case (state)
        IDLE: if (accept) state <= RUN;
        RUN:  if (handshake && final_beat && !accept) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (load) begin
        unzip_tvalid <= 1'b1;
        busy         <= 1'b1;
        unzip_tdata  <= beat_data;
        unzip_tkeep  <= beat_keep;
        unzip_tlast  <= beat_last;
      end else if (handshake && final_beat) begin
        unzip_tvalid <= 1'b0;
        busy         <= 1'b0;
        unzip_tdata  <= '0;
        unzip_tkeep  <= '0;
        unzip_tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_uncompress_range_multi.sv
// Bench for axis_uncompress_range_multi: four instances with different
// stride/lane/direction/tlast settings, driven with descriptors and checked
// against an address-list reference model.
module tb_axis_uncompress_range_multi;

  localparam int LIMIT = 3000;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic clk;
  logic rst;
  logic [3:0][15:0] zd;
  logic [3:0] zv, zl, zr, uv, ul, ur, bz;
  logic [3:0][63:0] ud;
  logic [3:0][7:0]  uk;

  logic [7:0]  ud_a, ud_c;
  logic [31:0] ud_b;
  logic [23:0] ud_d;
  logic [0:0]  uk_a, uk_c;
  logic [3:0]  uk_b;
  logic [2:0]  uk_d;

  assign ud[0] = 64'(ud_a);
  assign ud[1] = 64'(ud_b);
  assign ud[2] = 64'(ud_c);
  assign ud[3] = 64'(ud_d);
  assign uk[0] = 8'(uk_a);
  assign uk[1] = 8'(uk_b);
  assign uk[2] = 8'(uk_c);
  assign uk[3] = 8'(uk_d);

  int total = 0;
  int bad   = 0;

  int    d_start[$];
  int    d_len[$];
  int    d_last[$];
  beat_t exp_q[$];

  axis_uncompress_range_multi #(.ASIZE(8), .LSIZE(8), .STEP(1), .LANES(1),
    .DIR("INC"), .LAST_MODE("RUN")) u_a (
    .clock(clk), .rst(rst), .zip_tdata(zd[0]), .zip_tvalid(zv[0]),
    .zip_tlast(zl[0]), .zip_tready(zr[0]), .unzip_tdata(ud_a),
    .unzip_tkeep(uk_a), .unzip_tvalid(uv[0]), .unzip_tlast(ul[0]),
    .unzip_tready(ur[0]), .busy(bz[0]));

  axis_uncompress_range_multi #(.ASIZE(8), .LSIZE(8), .STEP(2), .LANES(4),
    .DIR("INC"), .LAST_MODE("RUN")) u_b (
    .clock(clk), .rst(rst), .zip_tdata(zd[1]), .zip_tvalid(zv[1]),
    .zip_tlast(zl[1]), .zip_tready(zr[1]), .unzip_tdata(ud_b),
    .unzip_tkeep(uk_b), .unzip_tvalid(uv[1]), .unzip_tlast(ul[1]),
    .unzip_tready(ur[1]), .busy(bz[1]));

  axis_uncompress_range_multi #(.ASIZE(8), .LSIZE(8), .STEP(3), .LANES(1),
    .DIR("DEC"), .LAST_MODE("RUN")) u_c (
    .clock(clk), .rst(rst), .zip_tdata(zd[2]), .zip_tvalid(zv[2]),
    .zip_tlast(zl[2]), .zip_tready(zr[2]), .unzip_tdata(ud_c),
    .unzip_tkeep(uk_c), .unzip_tvalid(uv[2]), .unzip_tlast(ul[2]),
    .unzip_tready(ur[2]), .busy(bz[2]));

  axis_uncompress_range_multi #(.ASIZE(8), .LSIZE(8), .STEP(5), .LANES(3),
    .DIR("DEC"), .LAST_MODE("PKT")) u_d (
    .clock(clk), .rst(rst), .zip_tdata(zd[3]), .zip_tvalid(zv[3]),
    .zip_tlast(zl[3]), .zip_tready(zr[3]), .unzip_tdata(ud_d),
    .unzip_tkeep(uk_d), .unzip_tvalid(uv[3]), .unzip_tlast(ul[3]),
    .unzip_tready(ur[3]), .busy(bz[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int p_lanes(input int i);
    case (i) 0: return 1; 1: return 4; 2: return 1; default: return 3; endcase
  endfunction
  function automatic int p_step(input int i);
    case (i) 0: return 1; 1: return 2; 2: return 3; default: return 5; endcase
  endfunction
  function automatic int p_dec(input int i);
    return (i >= 2) ? 1 : 0;
  endfunction
  function automatic int p_pkt(input int i);
    return (i == 3) ? 1 : 0;
  endfunction

  function automatic void push_desc(input int s, input int l, input int t);
    d_start.push_back(s);
    d_len.push_back(l);
    d_last.push_back(t);
  endfunction

  // Reference: list every address of the run, then cut it into LANES-wide beats.
  function automatic void add_run(input int i, input int s, input int l, input int t);
    int n, lanes;
    int addrs[$];
    beat_t b;
    n = l + 1;
    lanes = p_lanes(i);
    for (int e = 0; e < n; e++)
      addrs.push_back(p_dec(i) != 0 ? (s - e * p_step(i)) & 255 : (s + e * p_step(i)) & 255);
    for (int base = 0; base < n; base += lanes) begin
      b = '0;
      for (int k = 0; k < lanes; k++) begin
        if (base + k < n) begin
          b.d[k*8 +: 8] = 8'(addrs[base + k]);
          b.k[k] = 1'b1;
        end
      end
      b.l = (base + lanes >= n) && (p_pkt(i) == 0 || t != 0);
      exp_q.push_back(b);
    end
  endfunction

  // Drive the queued descriptors into instance i while checking its stream.
  task automatic run_stream(input int i, input string name, input int rdy_pct, input bit gapless);
    time acc_time;
    acc_time = 0;
    exp_q.delete();
    for (int n = 0; n < d_start.size(); n++) add_run(i, d_start[n], d_len[n], d_last[n]);
    fork
      begin : drv
        for (int n = 0; n < d_start.size(); n++) begin
          bit acc;
          int c;
          if (!gapless && $urandom_range(0, 2) == 0) begin
            zv[i] = 1'b0;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
          end
          zv[i] = 1'b1;
          zd[i] = {8'(d_start[n]), 8'(d_len[n])};
          zl[i] = 1'(d_last[n]);
          acc = 1'b0;
          c = 0;
          while (!acc && c < LIMIT) begin
            @(negedge clk);
            acc = zr[i];
            if (acc && n == 0) acc_time = $time + 5;
            @(posedge clk); #1;
            c++;
          end
          total++;
          if (!acc) begin
            bad++;
            $display("FAIL %s accept: descriptor %0d not taken within %0d cycles", name, n, LIMIT);
          end
        end
        zv[i] = 1'b0;
      end
      begin : mon
        int c, nb;
        bit first, held;
        beat_t hb, e;
        c = 0; nb = 0; first = 1'b1; held = 1'b0; hb = '0;
        while (exp_q.size() > 0 && c < LIMIT) begin
          ur[i] = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
          @(negedge clk);
          if (uv[i]) begin
            if (first) begin
              first = 1'b0;
              total++;
              if ($time - acc_time != 5) begin
                bad++;
                $display("FAIL %s latency: first valid %0t after accept, want 5", name, $time - acc_time);
              end
            end
            if (held) begin
              total++;
              if (ud[i] !== hb.d || uk[i] !== hb.k || ul[i] !== hb.l) begin
                bad++;
                $display("FAIL %s stall: got data=%h keep=%b last=%b, held data=%h keep=%b last=%b",
                         name, ud[i], uk[i], ul[i], hb.d, hb.k, hb.l);
              end
            end
            if (ur[i]) begin
              e = exp_q.pop_front();
              total++;
              if (ud[i] !== e.d || uk[i] !== e.k || ul[i] !== e.l) begin
                bad++;
                $display("FAIL %s beat%0d: got data=%h keep=%b last=%b, want data=%h keep=%b last=%b",
                         name, nb, ud[i], uk[i], ul[i], e.d, e.k, e.l);
              end
              nb++;
              held = 1'b0;
            end else begin
              held = 1'b1;
              hb.d = ud[i]; hb.k = uk[i]; hb.l = ul[i];
            end
          end else begin
            if (held) begin
              total++; bad++;
              $display("FAIL %s stall: tvalid dropped while stalled, got 0 want 1", name);
            end else if (!first && gapless) begin
              total++; bad++;
              $display("FAIL %s bubble: tvalid=0 before beat%0d, want 1", name, nb);
            end
            held = 1'b0;
          end
          @(posedge clk); #1;
          c++;
        end
        total++;
        if (exp_q.size() != 0) begin
          bad++;
          $display("FAIL %s timeout: %0d beats still expected after %0d cycles", name, exp_q.size(), LIMIT);
        end
        ur[i] = 1'b1;
        @(negedge clk);
        total++;
        if (uv[i] !== 1'b0 || bz[i] !== 1'b0 || zr[i] !== 1'b1) begin
          bad++;
          $display("FAIL %s idle: got tvalid=%b busy=%b zip_tready=%b, want 0 0 1", name, uv[i], bz[i], zr[i]);
        end
        @(posedge clk); #1;
      end
    join
    d_start.delete();
    d_len.delete();
    d_last.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (zr !== 4'b0000 || uv !== 4'b0000 || ul !== 4'b0000 || bz !== 4'b0000) begin
      bad++;
      $display("FAIL reset ctrl: got zr=%b uv=%b ul=%b busy=%b, want all 0", zr, uv, ul, bz);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ud[i] !== 64'd0 || uk[i] !== 8'd0) begin
        bad++;
        $display("FAIL reset data%0d: got data=%h keep=%b, want 0 0", i, ud[i], uk[i]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (zr !== 4'b1111 || uv !== 4'b0000) begin
      bad++;
      $display("FAIL reset release: got zr=%b uv=%b, want 1111 0000", zr, uv);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    push_desc(8'h10, 3, 0);
    run_stream(0, "basic", 100, 1'b1);
  endtask

  task automatic test_wrap_lanes();
    push_desc(8'hF8, 5, 0);
    run_stream(1, "wrap_lanes", 100, 1'b1);
  endtask

  task automatic test_decrement();
    push_desc(8'h02, 2, 0);
    run_stream(2, "decrement", 100, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) push_desc($urandom_range(0, 255), $urandom_range(0, 6), 0);
    run_stream(0, "backpressure", 50, 1'b0);
    push_desc(8'h00, 1, 0);
    push_desc(8'h40, 0, 0);
    run_stream(0, "back_to_back", 100, 1'b1);
  endtask

  task automatic test_pkt_mode();
    push_desc(8'h30, 4, 0);
    push_desc(8'h90, 1, 0);
    push_desc(8'h05, 3, 1);
    run_stream(3, "pkt_mode", 100, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    zd[0] = {8'h40, 8'h03};
    zl[0] = 1'b0;
    zv[0] = 1'b1;
    ur[0] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    zv[0] = 1'b0;
    @(negedge clk);
    total++;
    if (uv[0] !== 1'b1 || ud[0] !== 64'h40) begin
      bad++;
      $display("FAIL midrst beat0: got valid=%b data=%h, want 1 40", uv[0], ud[0]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (uv[0] !== 1'b1 || ud[0] !== 64'h41) begin
      bad++;
      $display("FAIL midrst beat1: got valid=%b data=%h, want 1 41", uv[0], ud[0]);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (uv[0] !== 1'b0 || ud[0] !== 64'd0 || ul[0] !== 1'b0 || bz[0] !== 1'b0 || zr[0] !== 1'b0) begin
      bad++;
      $display("FAIL midrst async: got valid=%b data=%h last=%b busy=%b zr=%b, want 0 0 0 0 0",
               uv[0], ud[0], ul[0], bz[0], zr[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (uv[0] !== 1'b0 || zr[0] !== 1'b1) begin
      bad++;
      $display("FAIL midrst resume: got valid=%b zr=%b, want 0 1", uv[0], zr[0]);
    end
    @(posedge clk); #1;
    push_desc(8'h20, 0, 0);
    run_stream(0, "after_reset", 100, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++)
      push_desc($urandom_range(0, 255), (n == 5) ? 255 : $urandom_range(0, 12), $urandom_range(0, 1));
    run_stream(1, "random_b", 60, 1'b0);
    for (int n = 0; n < 12; n++)
      push_desc($urandom_range(0, 255), $urandom_range(0, 12), $urandom_range(0, 1));
    run_stream(3, "random_d", 70, 1'b0);
    for (int n = 0; n < 8; n++)
      push_desc($urandom_range(0, 255), $urandom_range(0, 9), 0);
    run_stream(2, "random_c", 50, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    zd  = '0;
    zv  = '0;
    zl  = '0;
    ur  = '0;
    test_reset();
    test_basic();
    test_wrap_lanes();
    test_decrement();
    test_back_to_back();
    test_pkt_mode();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
